// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath width, default boot address and
// the fetch-queue entry layout.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } ifq_entry_t;

  // Force an address onto a 4-byte boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush and occupancy count. DEPTH must be a power of
// two so the pointers wrap on their own. A push on a full FIFO is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and count bookkeeping; flush drops everything at once.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (reset && !flush && do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues in-order word fetches to instruction memory,
// buffers returned words with their pc, and hands them to IF/ID. Redirect
// flushes the queue and discards responses still in flight.
// Optional feature: define IFQ_BYPASS_EN to forward a response straight to the
// consumer in its arrival cycle when the queue is empty.
module ifetch_queue
  import riscv_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  input  logic            instr_ready
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_addr, rsp_pc;
  logic [CW-1:0]   outstanding, drop, fifo_count;
  logic            grant, dropping, rsp_take, bypass;
  logic            fifo_push, fifo_pop, fifo_empty, fifo_full, head_valid;
  ifq_entry_t      rsp_entry, fifo_head, head;

  // Credit: every queued entry or in-flight request holds one slot.
  assign imem_req  = reset && !redirect &&
                     (({1'b0, fifo_count} + {1'b0, outstanding}) < DEPTH_W);
  assign imem_addr = fetch_addr;
  assign grant     = imem_req && imem_gnt;

  // Responses owed to a flushed stream are swallowed before new ones queue.
  assign dropping  = (drop != '0);
  assign rsp_take  = reset && imem_rvalid && !dropping && !redirect;
  assign rsp_entry = '{pc: rsp_pc, instr: imem_rdata};

`ifdef IFQ_BYPASS_EN
  assign bypass = fifo_empty && rsp_take;
`else
  assign bypass = 1'b0;
`endif

  assign head        = bypass ? rsp_entry : fifo_head;
  assign head_valid  = !fifo_empty || bypass;
  assign instr_valid = reset && !redirect && head_valid;
  assign instr       = reset ? head.instr : '0;
  assign pc          = reset ? head.pc    : '0;

  // A bypassed word that is consumed immediately never enters storage.
  assign fifo_pop  = instr_valid && instr_ready && !fifo_empty;
  assign fifo_push = rsp_take && !(bypass && instr_ready);

  sync_fifo #(
    .WIDTH ($bits(ifq_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .push  (fifo_push),
    .din   (rsp_entry),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // Fetch/response pc counters and in-flight tracking; redirect wins over all.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_addr  <= word_align(RESET_PC);
      rsp_pc      <= word_align(RESET_PC);
      outstanding <= '0;
      drop        <= '0;
    end else if (redirect) begin
      fetch_addr  <= word_align(redirect_pc);
      rsp_pc      <= word_align(redirect_pc);
      outstanding <= outstanding - CW'(imem_rvalid);
      drop        <= outstanding - CW'(imem_rvalid);
    end else begin
      if (grant)    fetch_addr <= fetch_addr + 32'd4;
      if (rsp_take) rsp_pc     <= rsp_pc + 32'd4;
      outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid);
      if (imem_rvalid && dropping) drop <= drop - 1'b1;
    end
  end

`ifndef SYNTHESIS
  // Memory must never answer more requests than were granted.
  always_ff @(posedge clk) begin
    if (reset && imem_rvalid)
      assert (outstanding != '0) else $error("ifetch_queue: rvalid without outstanding request");
    if (reset && fifo_push && !fifo_pop)
      assert (!fifo_full) else $error("ifetch_queue: push into full queue");
  end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue (DEPTH=4). Expected pcs are constants;
// instruction words come from a fixed address->data pattern.
module tb_ifetch_queue;

`ifdef IFQ_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset, imem_req, imem_gnt, imem_rvalid, redirect;
  logic        instr_valid, instr_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, pc;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc          (pc),
    .instr_ready (instr_ready)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1300_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic idle();
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    redirect = 0; redirect_pc = '0; instr_ready = 0;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 0; idle();
    imem_gnt = 1; instr_ready = 1;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", pc, 32'd0);
    next();
    reset = 1; idle();
  endtask

  initial begin
    logic        g_pend, g_now;
    logic [31:0] g_addr, g_addr_now, exp_pc;
    logic [31:0] got_pc [3];
    logic [31:0] got_in [3];
    int          grants, n;

    // --- Streaming fetch: gnt every cycle, rvalid one cycle later, ready=1
    do_reset();
    chk("rst_addr", imem_addr, 32'h0);
    instr_ready = 1;
    for (int k = 0; k < 7; k++) begin
      imem_gnt    = (k < 6);
      imem_rvalid = (k >= 1);
      imem_rdata  = (k >= 1) ? mem_word(32'(4 * (k - 1))) : 32'h0;
      #1;
      if (k < 6) begin
        chk("s1_req", 32'(imem_req), 32'd1);
        chk("s1_addr", imem_addr, 32'(4 * k));
      end
      if (k >= 1 + LAT) begin
        exp_pc = 32'(4 * (k - 1 - LAT));
        chk("s1_valid", 32'(instr_valid), 32'd1);
        chk("s1_pc", pc, exp_pc);
        chk("s1_instr", instr, mem_word(exp_pc));
      end else begin
        chk("s1_valid0", 32'(instr_valid), 32'd0);
      end
      next();
    end

    // --- Back-pressure: ready=0 for 10 cycles, credit limits grants to 4
    do_reset();
    g_pend = 0; g_addr = '0; grants = 0;
    for (int k = 0; k < 10; k++) begin
      imem_gnt    = 1;
      imem_rvalid = g_pend;
      imem_rdata  = mem_word(g_addr);
      #1;
      g_now      = imem_req && imem_gnt;
      g_addr_now = imem_addr;
      if (g_now) grants++;
      if (k >= 1 + LAT) begin
        chk("s2_valid", 32'(instr_valid), 32'd1);
        chk("s2_pc_hold", pc, 32'h0);
        chk("s2_instr_hold", instr, mem_word(32'h0));
      end
      next();
      g_pend = g_now;
      g_addr = g_addr_now;
    end
    idle();
    #1;
    chk("s2_grants", 32'(grants), 32'd4);
    chk("s2_req_low", 32'(imem_req), 32'd0);
    next();
    instr_ready = 1;
    for (int j = 0; j < 4; j++) begin
      #1;
      chk("s2_drain_valid", 32'(instr_valid), 32'd1);
      chk("s2_drain_pc", pc, 32'(4 * j));
      chk("s2_drain_instr", instr, mem_word(32'(4 * j)));
      next();
    end
    #1;
    chk("s2_empty", 32'(instr_valid), 32'd0);
    next();

    // --- Redirect with two requests in flight: both responses dropped
    do_reset();
    imem_gnt = 1; #1; chk("s3_addr0", imem_addr, 32'h0); next();
    imem_gnt = 1; #1; chk("s3_addr1", imem_addr, 32'h4); next();
    imem_gnt = 0; redirect = 1; redirect_pc = 32'h0000_0102;
    #1; chk("s3_req_redir", 32'(imem_req), 32'd0); next();
    redirect = 0; imem_gnt = 1; imem_rvalid = 1; imem_rdata = 32'hDEAD_0000;
    #1;
    chk("s3_req_new", 32'(imem_req), 32'd1);
    chk("s3_addr_new", imem_addr, 32'h0000_0100);
    chk("s3_drop1", 32'(instr_valid), 32'd0);
    next();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'hDEAD_0004;
    #1; chk("s3_drop2", 32'(instr_valid), 32'd0); next();
    imem_rvalid = 1; imem_rdata = mem_word(32'h0000_0100);
    #1; chk("s3_arrive", 32'(instr_valid), 32'(LAT == 0)); next();
    imem_rvalid = 0;
    #1;
    chk("s3_valid", 32'(instr_valid), 32'd1);
    chk("s3_pc", pc, 32'h0000_0100);
    chk("s3_instr", instr, mem_word(32'h0000_0100));
    next();

    // --- Redirect + pop + rvalid in the same cycle
    do_reset();
    imem_gnt = 1; #1; next();
    imem_gnt = 1; imem_rvalid = 1; imem_rdata = mem_word(32'h0); #1; next();
    imem_gnt = 1; imem_rvalid = 1; imem_rdata = mem_word(32'h4);
    instr_ready = 1; redirect = 1; redirect_pc = 32'h0000_0200;
    #1; chk("s4_req_redir", 32'(imem_req), 32'd0); next();
    redirect = 0; imem_rvalid = 0; imem_gnt = 1; instr_ready = 1;
    #1;
    chk("s4_flushed", 32'(instr_valid), 32'd0);
    chk("s4_addr", imem_addr, 32'h0000_0200);
    chk("s4_req", 32'(imem_req), 32'd1);
    next();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = mem_word(32'h200); instr_ready = 0;
    #1; chk("s4_arrive", 32'(instr_valid), 32'(LAT == 0)); next();
    imem_rvalid = 0;
    #1;
    chk("s4_valid", 32'(instr_valid), 32'd1);
    chk("s4_pc", pc, 32'h0000_0200);
    chk("s4_instr", instr, mem_word(32'h200));
    next();

    // --- Address wrap after redirect near the top of memory
    do_reset();
    redirect = 1; redirect_pc = 32'hFFFF_FFF8; next();
    redirect = 0; instr_ready = 1; n = 0;
    for (int k = 1; k < 8; k++) begin
      imem_gnt    = (k <= 3);
      imem_rvalid = (k >= 2 && k <= 4);
      imem_rdata  = mem_word(32'hFFFF_FFF8 + 32'(4 * (k - 2)));
      #1;
      if (k <= 3) chk("s5_addr", imem_addr, 32'hFFFF_FFF8 + 32'(4 * (k - 1)));
      if (instr_valid) begin
        if (n < 3) begin got_pc[n] = pc; got_in[n] = instr; end
        n++;
      end
      next();
    end
    idle();
    chk("s5_count", 32'(n), 32'd3);
    chk("s5_pc0", got_pc[0], 32'hFFFF_FFF8);
    chk("s5_pc1", got_pc[1], 32'hFFFF_FFFC);
    chk("s5_pc2", got_pc[2], 32'h0000_0000);
    chk("s5_in0", got_in[0], mem_word(32'hFFFF_FFF8));
    chk("s5_in2", got_in[2], mem_word(32'h0000_0000));

    // --- Response-to-valid latency on an empty queue; addr held without gnt
    do_reset();
    imem_gnt = 1; #1; next();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = mem_word(32'h0);
    #1;
    chk("s6_same_cycle", 32'(instr_valid), 32'(LAT == 0));
    chk("s6_addr_wait", imem_addr, 32'h4);
    next();
    imem_rvalid = 0;
    #1;
    chk("s6_next_cycle", 32'(instr_valid), 32'd1);
    chk("s6_pc", pc, 32'h0);
    chk("s6_instr", instr, mem_word(32'h0));
    chk("s6_addr_hold", imem_addr, 32'h4);
    next();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving queue entries and max in-flight requests (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port imem_req  out  1  fetch request to instruction memory.
REQ-006 SHALL have port imem_addr  out  32  word-aligned fetch address.
REQ-007 SHALL have port imem_gnt  in  1  request accepted this cycle.
REQ-008 SHALL have port imem_rvalid  in  1  response data valid.
REQ-009 SHALL have port imem_rdata  in  32  returned instruction word.
REQ-010 SHALL have port redirect  in  1  branch/jump taken; flush and refetch.
REQ-011 SHALL have port redirect_pc  in  32  new fetch address.
REQ-012 SHALL have port instr_valid  out  1  head entry valid toward IF/ID register.
REQ-013 SHALL have port instr  out  32  head instruction.
REQ-014 SHALL have port pc  out  32  address of head instruction.
REQ-015 SHALL have port instr_ready  in  1  consumer accepts head this cycle.

Function
REQ-016 SHALL transfer a request when imem_req && imem_gnt; imem_addr then advances by 4 next cycle, wrapping 32'hFFFF_FFFC -> 32'h0.
REQ-017 SHALL assert imem_req only when (queue count + outstanding) < DEPTH and redirect is low; imem_addr SHALL hold stable while imem_req is high without imem_gnt.
REQ-018 SHALL accept responses in request order, at least one cycle after grant; response pc SHALL come from a response-pc counter advanced by 4 per accepted response.
REQ-019 SHALL pop the head when instr_valid && instr_ready; instr/pc SHALL hold stable while instr_valid && !instr_ready.
REQ-020 SHALL support simultaneous push and pop when full or empty without loss; count unchanged on push+pop.
REQ-021 SHALL, on redirect, next cycle: empty the queue, set fetch and response-pc counters to {redirect_pc[31:2],2'b00}, drop count = outstanding not answered in the redirect cycle.
REQ-022 SHALL discard the next drop-count responses (rvalid counted, data not queued) before queuing new responses.
REQ-023 SHALL give redirect priority over pop, push and grant in the same cycle; those events SHALL have no effect on queue contents.
REQ-024 SHALL never overflow: rvalid with no credit is a protocol error; assertion fires in simulation.

Reset
REQ-025 SHALL, while reset==0 at a clock edge, drive imem_req=0, instr_valid=0, instr=0, pc=0, and set count=0, outstanding=0, drop=0, fetch address=RESET_PC.
REQ-026 SHALL, on reset mid-operation, abandon outstanding requests; responses arriving after reset release are discarded via drop count preset to 0 (memory is reset together with the core).

Configuration
REQ-027 SHALL, with IFQ_BYPASS_EN defined, present an arriving response on instr/pc/instr_valid in the same cycle when the queue is empty (combinational bypass), pushing only if not popped.
REQ-028 SHALL, without IFQ_BYPASS_EN, have minimum latency one cycle from imem_rvalid to instr_valid.

Structure
REQ-029 SHALL take XLEN=32, RESET_PC default and typedef struct ifq_entry_t {pc, instr} from shared package riscv_pkg.
REQ-030 SHALL instantiate one sub-module sync_fifo (parameterised width/depth, count output) for ifq_entry_t storage.

Verification
REQ-031 SHALL cover: reset release, gnt=1, rvalid one cycle after gnt, ready=1 -> pc sequence 0,4,8,C, instr matches memory.
REQ-032 SHALL cover: ready=0 for 10 cycles, DEPTH=4 -> exactly 4 grants, imem_req low, instr/pc held at pc=0.
REQ-033 SHALL cover: redirect to 32'h0000_0102 with 2 outstanding -> 2 responses dropped, next pc=32'h0000_0100.
REQ-034 SHALL cover: redirect+pop+rvalid same cycle -> queue empty next cycle, no entry delivered with old pc.
REQ-035 SHALL cover: redirect_pc=32'hFFFF_FFF8 -> pcs FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-036 SHALL cover: IFQ_BYPASS_EN on, empty queue, rvalid at cycle n -> instr_valid at cycle n; off -> cycle n+1.
